multicycle_ctrl_fsm: RTL
========================

MULTICYCLE_CTRL_FSM -- requirements
Module: multicycle_ctrl_fsm

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 32, width of the retired-instruction counter.
REQ-002 SHALL have port clk, input, 1; the single clock, rising edge.
REQ-003 SHALL have port reset, input, 1; asynchronous, active-high.
REQ-004 SHALL have port OpCode, input, 6; instruction bits [31:26], taken from IR.
REQ-005 SHALL have port Funct, input, 6; instruction bits [5:0], taken from IR.
REQ-006 SHALL have port MemReady, input, 1; memory access completes this cycle.
REQ-007 SHALL have write-enable outputs, each 1 bit: PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ExtOp (1 = sign-extend), LuiOp.
REQ-008 SHALL have select outputs, each 2 bits:
- RegDst: 00 rt, 01 rd, 10 $31.
- MemtoReg: 00 ALUOut, 01 MDR, 10 PC.
- ALUSrcA: 00 PC, 01 A, 10 shamt, 11 zero.
- ALUSrcB: 00 B, 01 const 4, 10 ext imm, 11 ext imm<<2.
- PCSource: 00 ALU result, 01 ALUOut, 10 jump target, 11 A.
REQ-009 SHALL have output ALUOp, 4 bits.
- Bits [2:0]: 000 add, 001 sub, 010 decode by Funct, 011 addu, 100 and, 101 slt.
- Bit [3]: 1 = unsigned.
REQ-010 SHALL have outputs State (3 bits, current state), Illegal (1 bit, one-cycle pulse) and InstCount (CNT_WIDTH bits, retired instructions).

Function
REQ-011 SHALL implement states IF=0, ID=1, EX=2, MEM=3, WB=4; codes 5-7 SHALL go to IF on the next edge.
REQ-012 Any output not named for a state SHALL be 0 in that state; outputs SHALL be decoded from State and IR fields.
REQ-013 IF SHALL drive MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=0000, PCSource=00.
- PCWrite and IRWrite SHALL equal MemReady.
- With MemReady=0 the FSM SHALL stay in IF; with MemReady=1 it SHALL go to ID.
REQ-014 ID SHALL drive ALUSrcA=00, ALUSrcB=11, ALUOp=0000, ExtOp=1.
- j (000010): PCWrite=1, PCSource=10, then IF.
- jal (000011): as j, plus RegWrite=1, RegDst=10, MemtoReg=10.
- jr (OpCode 0, Funct 001000): PCWrite=1, PCSource=11, then IF.
- Opcodes other than R-type, lw, sw, beq, j, jal, addi, addiu, andi, slti, sltiu, lui: Illegal=1 for one cycle, then IF, no writes.
- All other supported opcodes: then EX.
REQ-015 EX SHALL drive, per instruction class:
- R-type: ALUSrcA=01, ALUSrcB=00, ALUOp=0010; ALUSrcA=10 when Funct is 000000, 000010 or 000011; then WB.
- lw/sw (100011/101011): ALUSrcA=01, ALUSrcB=10, ExtOp=1, ALUOp=0000; then MEM.
- beq (000100): ALUSrcA=01, ALUSrcB=00, ALUOp=0001, PCWriteCond=1, PCSource=01; then IF.
- Immediates, all with ALUSrcB=10, then WB:
  - addi: ALUSrcA=01, ExtOp=1, ALUOp=0000.
  - addiu: ALUSrcA=01, ExtOp=1, ALUOp=1011.
  - andi: ALUSrcA=01, ExtOp=0, ALUOp=0100.
  - slti: ALUSrcA=01, ExtOp=1, ALUOp=0101.
  - sltiu: ALUSrcA=01, ExtOp=1, ALUOp=1101.
  - lui: ALUSrcA=11, LuiOp=1, ALUOp=0000.
REQ-016 MEM SHALL drive IorD=1, with MemRead=1 for lw or MemWrite=1 for sw.
- While MemReady=0 it SHALL hold MEM.
- MemWrite SHALL stay asserted every stall cycle; the sw store completes on the MemReady=1 cycle.
- On MemReady=1: lw goes to WB, sw goes to IF.
REQ-017 WB SHALL drive RegWrite=1, then go to IF.
- R-type: RegDst=01, MemtoReg=00.
- lw: RegDst=00, MemtoReg=01.
- Immediates: RegDst=00, MemtoReg=00.
REQ-018 InstCount SHALL increment by 1, wrapping modulo 2^CNT_WIDTH, on every edge that moves the FSM into IF from a non-IF state after a legal instruction.
- Illegal-opcode returns SHALL NOT count.
REQ-019 Illegal SHALL be registered: it is high for exactly the one cycle after the ID cycle that decoded the illegal opcode.

Reset
REQ-020 When reset=1, asynchronously: State=IF, InstCount=0, Illegal=0.
REQ-021 While reset=1, PCWrite, PCWriteCond, MemWrite, IRWrite, RegWrite and MemRead SHALL all be 0.
REQ-022 Reset asserted mid-instruction (any state, including a MEM stall) SHALL abort the instruction with no further writes; the first post-reset edge with MemReady=1 SHALL fetch.

Verification
REQ-023 addi, MemReady=1 -> State 0,1,2,4,0; RegWrite only in cycle 4; InstCount 0 to 1.
REQ-024 lw with MemReady low 3 cycles in MEM -> MEM held 3 extra cycles; MemRead=1 and IorD=1 throughout; then WB with MemtoReg=01.
REQ-025 beq -> IF, ID, EX (PCWriteCond=1, ALUOp=0001, PCSource=01), IF; no RegWrite.
REQ-026 jal -> in ID: PCWrite=1, RegWrite=1, RegDst=10, MemtoReg=10; next state IF; 2 cycles total.
REQ-027 OpCode 111111 -> Illegal pulses 1 cycle, no write enables, InstCount unchanged.
REQ-028 Reset pulsed during a sw MEM stall -> MemWrite drops immediately, State=0, InstCount=0.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Control FSM for a five-state multicycle MIPS-style datapath.
// Decodes IR fields and the current state into datapath selects and write enables.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IF    | fetch: read memory at PC, load IR and PC+4 when MemReady
//  ID    | decode/register read, branch target calc, j/jal/jr retire
//  EX    | ALU operation, address calc, or beq compare-and-branch
//  MEM   | data memory access for lw/sw, held until MemReady
//  WB    | register file write for R-type, lw and immediates
module multicycle_ctrl_fsm #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [5:0]           OpCode,
   input  logic [5:0]           Funct,
   input  logic                 MemReady,
   output logic                 PCWrite,
   output logic                 PCWriteCond,
   output logic                 IorD,
   output logic                 MemRead,
   output logic                 MemWrite,
   output logic                 IRWrite,
   output logic                 RegWrite,
   output logic                 ExtOp,
   output logic                 LuiOp,
   output logic [1:0]           RegDst,
   output logic [1:0]           MemtoReg,
   output logic [1:0]           ALUSrcA,
   output logic [1:0]           ALUSrcB,
   output logic [1:0]           PCSource,
   output logic [3:0]           ALUOp,
   output logic [2:0]           State,
   output logic                 Illegal,
   output logic [CNT_WIDTH-1:0] InstCount
);

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EX  = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } state_t;

   state_t state_q, state_d;
   logic   retire;

   logic is_r, is_lw, is_sw, is_beq, is_j, is_jal, is_jr, is_shift;
   logic is_addi, is_addiu, is_andi, is_slti, is_sltiu, is_lui, legal;

   assign is_r     = (OpCode == 6'b000000);
   assign is_lw    = (OpCode == 6'b100011);
   assign is_sw    = (OpCode == 6'b101011);
   assign is_beq   = (OpCode == 6'b000100);
   assign is_j     = (OpCode == 6'b000010);
   assign is_jal   = (OpCode == 6'b000011);
   assign is_addi  = (OpCode == 6'b001000);
   assign is_addiu = (OpCode == 6'b001001);
   assign is_andi  = (OpCode == 6'b001100);
   assign is_slti  = (OpCode == 6'b001010);
   assign is_sltiu = (OpCode == 6'b001011);
   assign is_lui   = (OpCode == 6'b001111);
   assign is_jr    = is_r && (Funct == 6'b001000);
   // sll/srl/sra take the shift amount on ALU port A
   assign is_shift = is_r && ((Funct == 6'b000000) || (Funct == 6'b000010) ||
                              (Funct == 6'b000011));
   assign legal    = is_r | is_lw | is_sw | is_beq | is_j | is_jal | is_addi |
                     is_addiu | is_andi | is_slti | is_sltiu | is_lui;

   assign State = state_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IF;
         Illegal   <= 1'b0;
         InstCount <= '0;
      end else begin
         state_q <= state_d;
         Illegal <= (state_q == S_ID) && !legal;
         if (retire)
            InstCount <= InstCount + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   always_comb begin
      state_d     = S_IF;
      retire      = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      ExtOp       = 1'b0;
      LuiOp       = 1'b0;
      RegDst      = 2'b00;
      MemtoReg    = 2'b00;
      ALUSrcA     = 2'b00;
      ALUSrcB     = 2'b00;
      PCSource    = 2'b00;
      ALUOp       = 4'b0000;

      case (state_q)
         S_IF: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            PCWrite = MemReady;
            IRWrite = MemReady;
            state_d = MemReady ? S_ID : S_IF;
         end
         S_ID: begin
            ALUSrcB = 2'b11;
            ExtOp   = 1'b1;
            if (is_j || is_jal) begin
               PCWrite  = 1'b1;
               PCSource = 2'b10;
               retire   = 1'b1;
               if (is_jal) begin
                  RegWrite = 1'b1;
                  RegDst   = 2'b10;
                  MemtoReg = 2'b10;
               end
            end else if (is_jr) begin
               PCWrite  = 1'b1;
               PCSource = 2'b11;
               retire   = 1'b1;
            end else if (legal) begin
               state_d = S_EX;
            end
         end
         S_EX: begin
            if (is_r) begin
               ALUSrcA = is_shift ? 2'b10 : 2'b01;
               ALUOp   = 4'b0010;
               state_d = S_WB;
            end else if (is_lw || is_sw) begin
               ALUSrcA = 2'b01;
               ALUSrcB = 2'b10;
               ExtOp   = 1'b1;
               state_d = S_MEM;
            end else if (is_beq) begin
               ALUSrcA     = 2'b01;
               ALUOp       = 4'b0001;
               PCWriteCond = 1'b1;
               PCSource    = 2'b01;
               retire      = 1'b1;
            end else begin
               ALUSrcB = 2'b10;
               state_d = S_WB;
               if (is_lui) begin
                  ALUSrcA = 2'b11;
                  LuiOp   = 1'b1;
               end else begin
                  ALUSrcA = 2'b01;
                  ExtOp   = !is_andi;
                  if (is_addiu)      ALUOp = 4'b1011;
                  else if (is_andi)  ALUOp = 4'b0100;
                  else if (is_slti)  ALUOp = 4'b0101;
                  else if (is_sltiu) ALUOp = 4'b1101;
                  else               ALUOp = 4'b0000;
               end
            end
         end
         S_MEM: begin
            IorD     = 1'b1;
            MemRead  = is_lw;
            MemWrite = is_sw;
            if (!MemReady) begin
               state_d = S_MEM;
            end else if (is_lw) begin
               state_d = S_WB;
            end else begin
               retire = 1'b1;
            end
         end
         S_WB: begin
            RegWrite = 1'b1;
            RegDst   = is_r ? 2'b01 : 2'b00;
            MemtoReg = is_lw ? 2'b01 : 2'b00;
            retire   = 1'b1;
         end
         default: state_d = S_IF;
      endcase

      // An asserted reset must never let a write or read strobe escape
      if (reset) begin
         PCWrite     = 1'b0;
         PCWriteCond = 1'b0;
         MemWrite    = 1'b0;
         IRWrite     = 1'b0;
         RegWrite    = 1'b0;
         MemRead     = 1'b0;
      end
   end

endmodule
